// File: rtl/apb_master_bridge_if.sv
// Request/response channel plus APB bus for apb_master_bridge.
// master = bridge view, slave = requester/peripheral environment view.
interface apb_master_bridge_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic              req_write;
   logic [DATA_W-1:0] req_wdata;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_slverr;
   logic              rsp_timeout;

   logic [ADDR_W-1:0] paddr;
   logic              pselx;
   logic              penable;
   logic              pwrite;
   logic [DATA_W-1:0] pwdata;
   logic              pready;
   logic              pslverr;
   logic [DATA_W-1:0] prdata;

   modport master (
      input  req_valid, req_addr, req_write, req_wdata,
      output req_ready,
      output rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
      input  rsp_ready,
      output paddr, pselx, penable, pwrite, pwdata,
      input  pready, pslverr, prdata
   );

   modport slave (
      output req_valid, req_addr, req_write, req_wdata,
      input  req_ready,
      input  rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
      output rsp_ready,
      input  paddr, pselx, penable, pwrite, pwdata,
      output pready, pslverr, prdata
   );
endinterface

// File: rtl/apb_master_bridge.sv
// Valid/ready request -> APB SETUP/ACCESS transfer -> valid/ready response, one in flight.
// Optional ACCESS-phase timeout: define APB_MASTER_TIMEOUT_EN.
module apb_master_bridge #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input logic                 pclk,
   input logic                 prst,
   apb_master_bridge_if.master bus
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic              pwrite_q, pwrite_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;
   logic              psel_q, psel_d;
   logic              pen_q, pen_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_slverr_q, rsp_slverr_d;
   logic              timeout_hit;

`ifdef APB_MASTER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rsp_timeout_q, rsp_timeout_d;

   // This edge is the TIMEOUT_CYCLES-th ACCESS cycle without pready.
   assign timeout_hit     = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
   assign bus.rsp_timeout = rsp_timeout_q;
`else
   logic unused_timeout_cycles;

   assign unused_timeout_cycles = |TIMEOUT_CYCLES;
   assign timeout_hit           = 1'b0;
   assign bus.rsp_timeout       = 1'b0;
`endif

   assign bus.req_ready  = (state_q == IDLE) && !prst;
   assign bus.paddr      = paddr_q;
   assign bus.pwrite     = pwrite_q;
   assign bus.pwdata     = pwdata_q;
   assign bus.pselx      = psel_q;
   assign bus.penable    = pen_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_rdata  = rsp_rdata_q;
   assign bus.rsp_slverr = rsp_slverr_q;

   always_ff @(posedge pclk) begin
      if (prst) begin
         state_q       <= IDLE;
         paddr_q       <= '0;
         pwrite_q      <= 1'b0;
         pwdata_q      <= '0;
         psel_q        <= 1'b0;
         pen_q         <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_slverr_q  <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
         cnt_q         <= '0;
         rsp_timeout_q <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         paddr_q       <= paddr_d;
         pwrite_q      <= pwrite_d;
         pwdata_q      <= pwdata_d;
         psel_q        <= psel_d;
         pen_q         <= pen_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_slverr_q  <= rsp_slverr_d;
`ifdef APB_MASTER_TIMEOUT_EN
         cnt_q         <= cnt_d;
         rsp_timeout_q <= rsp_timeout_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.req_valid) state_d = SETUP;
         SETUP:   state_d = ACCESS;
         ACCESS:  if (bus.pready || timeout_hit) state_d = RESP;
         RESP:    if (bus.rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      paddr_d       = paddr_q;
      pwrite_d      = pwrite_q;
      pwdata_d      = pwdata_q;
      psel_d        = psel_q;
      pen_d         = pen_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_slverr_d  = rsp_slverr_q;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_d         = cnt_q;
      rsp_timeout_d = rsp_timeout_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               paddr_d  = bus.req_addr;
               pwrite_d = bus.req_write;
               pwdata_d = bus.req_wdata;
               psel_d   = 1'b1;
               pen_d    = 1'b0;
            end
         end
         SETUP: begin
            pen_d = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
            cnt_d = '0;
`endif
         end
         ACCESS: begin
            // pready wins over a timeout landing on the same edge.
            if (bus.pready) begin
               psel_d       = 1'b0;
               pen_d        = 1'b0;
               rsp_valid_d  = 1'b1;
               rsp_rdata_d  = pwrite_q ? '0 : bus.prdata;
               rsp_slverr_d = bus.pslverr;
`ifdef APB_MASTER_TIMEOUT_EN
               rsp_timeout_d = 1'b0;
            end else if (timeout_hit) begin
               psel_d        = 1'b0;
               pen_d         = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_rdata_d   = '0;
               rsp_slverr_d  = 1'b1;
               rsp_timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
`endif
            end
         end
         RESP: begin
            if (bus.rsp_ready) rsp_valid_d = 1'b0;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: vector table of transfers plus reset,
// throughput, mid-transfer reset and ACCESS-timeout sequences.
module tb_apb_master_bridge;

   logic pclk = 1'b0;
   logic prst;
   int   checks = 0;
   int   errors = 0;

   always #5 pclk = ~pclk;

   apb_master_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
      .pclk (pclk),
      .prst (prst),
      .bus  (bus)
   );

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          waits;
      logic        slverr;
      logic [31:0] prdata;
      int          rsp_delay;
      logic [31:0] exp_rdata;
      logic        exp_slverr;
   } vec_t;

   vec_t vecs [5];

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic xfer(input vec_t v);
      bus.rsp_ready = 1'b0;
      bus.pready    = 1'b0;
      chk("pre_req_ready", bus.req_ready, 1);
      bus.req_valid = 1'b1;
      bus.req_addr  = v.addr;
      bus.req_write = v.wr;
      bus.req_wdata = v.wdata;
      tick();
      bus.req_valid = 1'b0;
      bus.req_addr  = ~v.addr;
      bus.req_wdata = ~v.wdata;
      chk("setup_pselx", bus.pselx, 1);
      chk("setup_penable", bus.penable, 0);
      chk("setup_paddr", bus.paddr, v.addr);
      chk("setup_pwrite", bus.pwrite, v.wr);
      chk("setup_pwdata", bus.pwdata, v.wdata);
      chk("setup_req_ready", bus.req_ready, 0);
      tick();
      chk("access_penable", bus.penable, 1);
      chk("access_pselx", bus.pselx, 1);
      chk("access_paddr", bus.paddr, v.addr);
      chk("access_pwdata", bus.pwdata, v.wdata);
      for (int i = 0; i <= v.waits; i++) begin
         if (i < v.waits) begin
            bus.pready  = 1'b0;
            bus.pslverr = ~v.slverr;
            bus.prdata  = ~v.prdata;
         end else begin
            bus.pready  = 1'b1;
            bus.pslverr = v.slverr;
            bus.prdata  = v.prdata;
         end
         tick();
         if (i < v.waits) begin
            chk("wait_rsp_valid", bus.rsp_valid, 0);
            chk("wait_penable", bus.penable, 1);
            chk("wait_paddr", bus.paddr, v.addr);
         end else begin
            chk("done_pselx", bus.pselx, 0);
            chk("done_penable", bus.penable, 0);
            chk("done_rsp_valid", bus.rsp_valid, 1);
            chk("done_rsp_rdata", bus.rsp_rdata, v.exp_rdata);
            chk("done_rsp_slverr", bus.rsp_slverr, v.exp_slverr);
            chk("done_rsp_timeout", bus.rsp_timeout, 0);
         end
      end
      bus.pready  = 1'b0;
      bus.pslverr = 1'b0;
      bus.prdata  = 32'h0BAD_0BAD;
      for (int d = 0; d < v.rsp_delay; d++) begin
         tick();
         chk("hold_rsp_valid", bus.rsp_valid, 1);
         chk("hold_rsp_rdata", bus.rsp_rdata, v.exp_rdata);
         chk("hold_req_ready", bus.req_ready, 0);
      end
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      chk("post_rsp_valid", bus.rsp_valid, 0);
      chk("post_req_ready", bus.req_ready, 1);
      chk("post_paddr_kept", bus.paddr, v.addr);
   endtask

   initial begin
      int setups, overlap, bad;

      vecs[0] = '{1'b1, 32'h10,        32'hA5A5_0001, 0, 1'b0, 32'h1111_2222, 0, 32'h0,         1'b0};
      vecs[1] = '{1'b0, 32'h10,        32'h0,         3, 1'b0, 32'hA5A5_0001, 0, 32'hA5A5_0001, 1'b0};
      vecs[2] = '{1'b1, 32'h20,        32'h1234_5678, 0, 1'b1, 32'hDEAD_BEEF, 5, 32'h0,         1'b1};
      vecs[3] = '{1'b0, 32'h24,        32'h5555_5555, 1, 1'b1, 32'hCAFE_F00D, 2, 32'hCAFE_F00D, 1'b1};
      vecs[4] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         0, 1'b0, 32'h8000_0001, 1, 32'h8000_0001, 1'b0};

      prst          = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'h44;
      bus.req_write = 1'b1;
      bus.req_wdata = 32'h99;
      bus.rsp_ready = 1'b0;
      bus.pready    = 1'b1;
      bus.pslverr   = 1'b0;
      bus.prdata    = 32'h0;
      tick();
      tick();
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_pselx", bus.pselx, 0);
      chk("rst_penable", bus.penable, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_paddr", bus.paddr, 0);
      chk("rst_rsp_timeout", bus.rsp_timeout, 0);
      prst          = 1'b0;
      bus.req_valid = 1'b0;
      bus.pready    = 1'b0;
      #1;
      chk("idle_req_ready", bus.req_ready, 1);
      tick();

      for (int i = 0; i < 5; i++) xfer(vecs[i]);

      // Back-to-back with zero-wait slave and rsp_ready high: one SETUP every 4 cycles.
      bus.req_addr  = 32'h30;
      bus.req_write = 1'b1;
      bus.req_wdata = 32'h3030_3030;
      bus.pready    = 1'b1;
      bus.rsp_ready = 1'b1;
      bus.req_valid = 1'b1;
      setups  = 0;
      overlap = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (bus.pselx && !bus.penable) setups++;
         if (bus.rsp_valid && bus.pselx) overlap++;
      end
      bus.req_valid = 1'b0;
      bus.pready    = 1'b0;
      bus.rsp_ready = 1'b0;
      chk("thru_setups", setups, 3);
      chk("thru_overlap", overlap, 0);
      chk("thru_req_ready", bus.req_ready, 1);

      // Reset during an ACCESS wait, with pready arriving on the reset edge.
      bus.req_addr  = 32'h50;
      bus.req_write = 1'b0;
      bus.req_valid = 1'b1;
      tick();
      bus.req_valid = 1'b0;
      tick();
      tick();
      chk("mid_pselx_before", bus.pselx, 1);
      chk("mid_penable_before", bus.penable, 1);
      prst       = 1'b1;
      bus.pready = 1'b1;
      bus.prdata = 32'h77;
      tick();
      chk("mid_pselx", bus.pselx, 0);
      chk("mid_penable", bus.penable, 0);
      chk("mid_rsp_valid", bus.rsp_valid, 0);
      chk("mid_paddr", bus.paddr, 0);
      prst       = 1'b0;
      bus.pready = 1'b0;
      bad = 0;
      for (int c = 0; c < 3; c++) begin
         tick();
         if (bus.rsp_valid) bad++;
      end
      chk("mid_no_rsp", bad, 0);
      chk("mid_req_ready", bus.req_ready, 1);

      // Slave never answers.
      bus.req_addr  = 32'h60;
      bus.req_write = 1'b0;
      bus.req_valid = 1'b1;
      bus.prdata    = 32'h6666_6666;
      tick();
      bus.req_valid = 1'b0;
      tick();
`ifdef APB_MASTER_TIMEOUT_EN
      bad = 0;
      for (int c = 0; c < 15; c++) begin
         tick();
         if (bus.rsp_valid || !bus.pselx) bad++;
      end
      chk("to_early", bad, 0);
      tick();
      chk("to_rsp_valid", bus.rsp_valid, 1);
      chk("to_rsp_slverr", bus.rsp_slverr, 1);
      chk("to_rsp_timeout", bus.rsp_timeout, 1);
      chk("to_rsp_rdata", bus.rsp_rdata, 0);
      chk("to_pselx", bus.pselx, 0);
      chk("to_penable", bus.penable, 0);
      bus.pready = 1'b1;
      tick();
      bus.pready = 1'b0;
      chk("to_late_pready_rdata", bus.rsp_rdata, 0);
      chk("to_late_pready_timeout", bus.rsp_timeout, 1);
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      chk("to_rsp_done", bus.rsp_valid, 0);
      chk("to_req_ready", bus.req_ready, 1);
`else
      bad = 0;
      for (int c = 0; c < 100; c++) begin
         tick();
         if (!bus.pselx || !bus.penable || bus.rsp_valid) bad++;
      end
      chk("nto_hold", bad, 0);
      chk("nto_rsp_timeout", bus.rsp_timeout, 0);
      prst = 1'b1;
      tick();
      prst = 1'b0;
      tick();
      chk("nto_reset_pselx", bus.pselx, 0);
      chk("nto_req_ready", bus.req_ready, 1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
